// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit common-anode 7-segment scanner.
// Scans MSD first and registers active-low segments with slot-edge blanking and leading-zero suppression.
module seven_seg_scanner #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] hex_in,
  input  logic       lz_en,
  input  logic [3:0] dp_mask,
  output logic [3:0] sel,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [CNT_W-1:0] LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK = CNT_W'(BLANK_CYC);

  state_t           state_q;
  logic [CNT_W-1:0] div_cnt_q;
  logic [1:0]       idx_q;
  logic             nz_seen_q;
  logic [3:0]       sel_q;
  logic [6:0]       seg_q;
  logic             dp_q;
  logic             frame_done_q;

  logic             slot_end;
  logic [1:0]       idx_d;
  logic [6:0]       glyph;
  logic [6:0]       seg_d;
  logic             dp_d;

  always_comb begin
    unique case (hex_in)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  end

  // Blanking on the final slot cycle keeps the old pattern off while sel moves.
  always_comb begin
    slot_end = (div_cnt_q == LAST);
    idx_d    = idx_q - 2'd1;
    seg_d    = '1;
    dp_d     = 1'b1;
    if (state_q == SCAN && div_cnt_q >= BLANK && !slot_end &&
        !(lz_en && !nz_seen_q && hex_in == 4'h0 && idx_q != 2'd0)) begin
      seg_d = glyph;
      dp_d  = ~dp_mask[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      idx_q        <= 2'd3;
      nz_seen_q    <= 1'b0;
      sel_q        <= '1;
      seg_q        <= '1;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      if (state_q == IDLE) begin
        state_q      <= SCAN;
        sel_q        <= 4'b0111;
        idx_q        <= 2'd3;
        div_cnt_q    <= '0;
        frame_done_q <= 1'b0;
      end else begin
        frame_done_q <= slot_end && (idx_q == 2'd0);
        if (slot_end) begin
          div_cnt_q <= '0;
          idx_q     <= idx_d;
          sel_q     <= ~(4'b0001 << idx_d);
          nz_seen_q <= (idx_q == 2'd0) ? 1'b0 : (nz_seen_q | (hex_in != 4'h0));
        end else begin
          div_cnt_q <= div_cnt_q + 1'b1;
        end
      end
    end
  end

  assign sel        = sel_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: directed and random stimulus against a slot/frame arithmetic model.
module tb_seven_seg_scanner;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * SD;

  logic       clk = 1'b0;
  logic       rst_n, en, lz_en, dp, frame_done;
  logic [3:0] hex_in, dp_mask, sel;
  logic [6:0] seg;
  logic [15:0] counter;

  int tests = 0;
  int fails = 0;
  bit m_run = 1'b0;
  int m_k   = 0;
  logic [6:0] dec [16];

  seven_seg_scanner #(.SCAN_DIV(SD), .BLANK_CYC(BC), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hex_in(hex_in), .lz_en(lz_en),
    .dp_mask(dp_mask), .sel(sel), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // External digit multiplexer driven by the scanner's select lines
  always_comb begin
    case (sel)
      4'b0111: hex_in = counter[15:12];
      4'b1011: hex_in = counter[11:8];
      4'b1101: hex_in = counter[7:4];
      4'b1110: hex_in = counter[3:0];
      default: hex_in = 4'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %h exp %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: predict outputs from the current inputs and scan position, then compare
  task automatic cyc();
    logic [3:0] es, h;
    logic [6:0] eg;
    logic       ed, ef;
    int         d, i, i2;
    bit         nz, blank;
    if (!rst_n || !en) begin
      es = 4'hF; eg = 7'h7F; ed = 1'b1; ef = 1'b0;
      m_run = 1'b0; m_k = 0;
    end else if (!m_run) begin
      es = 4'b0111; eg = 7'h7F; ed = 1'b1; ef = 1'b0;
      m_run = 1'b1; m_k = 0;
    end else begin
      d  = m_k % SD;
      i  = 3 - (m_k / SD) % 4;
      h  = 4'((32'(counter) >> (4 * i)) & 32'hF);
      nz = (i == 3) ? 1'b0 : ((32'(counter) >> (4 * (i + 1))) != 0);
      blank = (d < BC) || (d == SD - 1) || (lz_en && !nz && h == 4'h0 && i != 0);
      eg = blank ? 7'h7F : dec[h];
      ed = blank ? 1'b1 : ~dp_mask[i];
      ef = (d == SD - 1) && (i == 0);
      m_k++;
      i2 = 3 - (m_k / SD) % 4;
      es = ~(4'b0001 << i2);
    end
    @(posedge clk);
    #1;
    chk("sel", 7'(sel), 7'(es));
    chk("seg", seg, eg);
    chk("dp", 7'(dp), 7'(ed));
    chk("frame_done", 7'(frame_done), 7'(ef));
  endtask

  task automatic to_frame_start();
    for (int n = 0; n < FR + 4; n++) begin
      if (m_run && (m_k % FR) == 0) break;
      cyc();
    end
  endtask

  initial begin
    dec = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst_n = 1'b0; en = 1'b1; lz_en = 1'b0; dp_mask = 4'h0; counter = 16'h1234;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (2 * FR + 1) cyc();

    to_frame_start();
    counter = 16'h0050; lz_en = 1'b1;
    repeat (FR) cyc();
    lz_en = 1'b0;
    repeat (FR) cyc();

    to_frame_start();
    counter = 16'h0000; lz_en = 1'b1;
    repeat (FR) cyc();
    counter = 16'h1000;
    repeat (FR) cyc();

    counter = 16'h1234; lz_en = 1'b0; dp_mask = 4'b0100;
    repeat (FR) cyc();

    for (int n = 0; n < FR + 4; n++) begin
      if (m_run && (m_k % FR) == 2 * SD + 3) break;
      cyc();
    end
    en = 1'b0;
    cyc();
    en = 1'b1;
    repeat (FR + 8) cyc();

    for (int n = 0; n < 700; n++) begin
      if (m_run && (m_k % FR) == 0)
        counter = 16'($urandom) >> (4 * $urandom_range(0, 4));
      lz_en   = 1'($urandom);
      dp_mask = 4'($urandom);
      en      = ($urandom_range(0, 99) != 0);
      rst_n   = ($urandom_range(0, 199) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
